// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
//
// A single 1-bit full adder is reused once per clock, LSB first, to add two
// WIDTH-bit operands plus a carry-in. The result is presented with a
// valid/ready handshake and held stable until the consumer acknowledges it.
// A new operation may be accepted in the same cycle the previous result is
// acknowledged, so back-to-back operations need no idle cycle.
//
// Optional feature (macro SERIAL_ADD_SUB_EN): adds input op_sub. When op_sub=1
// at acceptance, the block computes A + ~B + 1 (cin ignored). In that case
// cout=1 means "no borrow".
//
// Ports:
//   clk        in   clock, rising-edge active
//   rst_n      in   asynchronous active-low reset
//   start      in   request a new operation (sampled only when acceptable)
//   a, b       in   operands, captured on acceptance
//   cin        in   carry-in, captured on acceptance
//   op_sub     in   subtract select (only with SERIAL_ADD_SUB_EN)
//   busy       out  high while bits are being processed
//   sum        out  result, valid while res_valid is high
//   cout       out  final carry-out, valid while res_valid is high
//   res_valid  out  result available
//   res_ready  in   consumer acknowledge of the result
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             op_sub,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] op_b;
    logic             op_c;
    logic             fa_sum;
    logic             fa_carry;

    // A new operation is taken from IDLE, or from DONE in the acknowledge cycle.
    assign accept   = start && ((state_q == StIdle) || ((state_q == StDone) && res_ready));
    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is folded in at capture time: invert B and force carry-in to 1.
    assign op_b = op_sub ? ~b : b;
    assign op_c = op_sub ? 1'b1 : cin;
`else
    assign op_b = b;
    assign op_c = cin;
`endif

    // The one shared full adder; operand registers shift right so bit 0 is current.
    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_bit) state_d = StDone;
            StDone:  if (res_ready) state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next values; status flags are decoded from the next state so
    // busy and res_valid come straight from flops.
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (accept) begin
            a_d     = a;
            b_d     = op_b;
            carry_d = op_c;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
        end else if (state_q == StRun) begin
            sum_d[cnt_q] = fa_sum;
            carry_d      = fa_carry;
            a_d          = a_q >> 1;
            b_d          = b_q >> 1;
            if (last_bit) begin
                cout_d = fa_carry;
            end else begin
                // Counter stops at WIDTH-1 so it never wraps within an operation.
                cnt_d = cnt_q + CntW'(1);
            end
        end
        busy_d  = (state_d == StRun);
        valid_d = (state_d == StDone);
    end

    // Outputs.
    always_comb begin
        busy      = busy_q;
        res_valid = valid_q;
        sum       = sum_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8. Expected results come
// from plain integer arithmetic on the operands.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         res_ready = 1'b0;
    logic         busy;
    logic [W-1:0] sum;
    logic         cout;
    logic         res_valid;
`ifdef SERIAL_ADD_SUB_EN
    logic         op_sub = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .busy      (busy),
        .sum       (sum),
        .cout      (cout),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    // Reference: {cout, sum} from integer arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic ci, input logic sub);
        logic [W:0] r;
        if (sub) begin
            r[W]     = (av >= bv);
            r[W-1:0] = av - bv;
        end else begin
            r = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
        op_sub = s;
`else
        if (s) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
    endtask

    task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic ci, input logic sub);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = ci;
        set_sub(sub);
        tick();
        start = 1'b0;
    endtask

    // Called right after the accepting edge. Scrambles start/operands during
    // RUN, checks partial sum bits, latency, busy duration and final result.
    task automatic wait_result(input logic [W:0] exp, input string nm);
        int           edges;
        int           busy_cnt;
        logic [W-1:0] mask;
        edges    = 1;
        busy_cnt = 0;
        while (!res_valid && edges < 4 * W) begin
            mask = W'((1 << (edges - 1)) - 1);
            checks++;
            if (sum !== (exp[W-1:0] & mask)) begin
                errors++;
                $display("FAIL %s partial_sum edge %0d: got %h want %h", nm, edges, sum,
                         exp[W-1:0] & mask);
            end
            if (busy) busy_cnt++;
            start = 1'($urandom_range(0, 1));
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom_range(0, 1));
            set_sub(1'($urandom_range(0, 1)) & sub_enabled());
            tick();
            edges++;
        end
        start = 1'b0;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: res_valid got %b want 1", nm, res_valid);
        end
        checks++;
        if (edges != W + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", nm, edges, W + 1);
        end
        checks++;
        if (busy_cnt != W) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_cnt, W);
        end
        checks++;
        if ({cout, sum} !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: got cout=%b sum=%h busy=%b want cout=%b sum=%h busy=0",
                     nm, cout, sum, busy, exp[W], exp[W-1:0]);
        end
    endtask

    function automatic logic sub_enabled();
`ifdef SERIAL_ADD_SUB_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic consume(input string nm);
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s consume: got valid=%b busy=%b want 0/0", nm, res_valid, busy);
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: got busy=%b valid=%b sum=%h cout=%b want all 0",
                     nm, busy, res_valid, sum, cout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        check_zero("reset_async");
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        tick();
        tick();
        check_zero("reset_held");
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        check_zero("reset_release");
    endtask

    task automatic test_directed();
        accept_op(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_result(model(8'h0F, 8'h01, 1'b0, 1'b0), "add_0f_01");
        consume("add_0f_01");
        accept_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_result(model(8'hFF, 8'h01, 1'b0, 1'b0), "add_ff_01");
        consume("add_ff_01");
        accept_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_result(model(8'hFF, 8'hFF, 1'b1, 1'b0), "add_ff_ff_c");
        consume("add_ff_ff_c");
    endtask

    task automatic test_hold();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W:0]   exp;
        av  = W'($urandom);
        bv  = W'($urandom);
        exp = model(av, bv, 1'b1, 1'b0);
        accept_op(av, bv, 1'b1, 1'b0);
        wait_result(exp, "hold_setup");
        for (int i = 0; i < 5; i++) begin
            res_ready = 1'b0;
            start     = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if ({cout, sum} !== exp || res_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got valid=%b cout=%b sum=%h want 1/%b/%h",
                         i, res_valid, cout, sum, exp[W], exp[W-1:0]);
            end
        end
        res_ready = 1'b1;
        start     = 1'b1;
        a         = 8'h02;
        b         = 8'h03;
        cin       = 1'b0;
        set_sub(1'b0);
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_b2b enter_run: got busy=%b valid=%b want 1/0", busy, res_valid);
        end
        wait_result(model(8'h02, 8'h03, 1'b0, 1'b0), "hold_b2b");
        consume("hold_b2b");
    endtask

    task automatic test_abort();
        accept_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("abort_async");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_zero("abort_no_result");
        accept_op(8'h10, 8'h20, 1'b0, 1'b0);
        wait_result(model(8'h10, 8'h20, 1'b0, 1'b0), "after_abort");
        consume("after_abort");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         ci;
        logic         sb;
        av = W'($urandom);
        bv = W'($urandom);
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1)) & sub_enabled();
        accept_op(av, bv, ci, sb);
        for (int i = 0; i < 16; i++) begin
            wait_result(model(av, bv, ci, sb), "random");
            av = W'($urandom);
            bv = W'($urandom);
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1)) & sub_enabled();
            if ($urandom_range(0, 1) == 1) begin
                res_ready = 1'b1;
                start     = 1'b1;
                a         = av;
                b         = bv;
                cin       = ci;
                set_sub(sb);
                tick();
                res_ready = 1'b0;
                start     = 1'b0;
                checks++;
                if (busy !== 1'b1 || res_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b enter_run %0d: got busy=%b valid=%b want 1/0",
                             i, busy, res_valid);
                end
            end else begin
                consume("random");
                accept_op(av, bv, ci, sb);
            end
        end
        wait_result(model(av, bv, ci, sb), "random_last");
        consume("random_last");
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        accept_op(8'h05, 8'h07, 1'b0, 1'b1);
        wait_result(model(8'h05, 8'h07, 1'b0, 1'b1), "sub_05_07");
        consume("sub_05_07");
        accept_op(8'h07, 8'h05, 1'b1, 1'b1);
        wait_result(model(8'h07, 8'h05, 1'b0, 1'b1), "sub_07_05_cin_ignored");
        consume("sub_07_05");
        accept_op(8'h33, 8'h11, 1'b1, 1'b0);
        wait_result(model(8'h33, 8'h11, 1'b1, 1'b0), "sub_mode_add");
        consume("sub_mode_add");
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_abort();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
